// File: rtl/coproc_cmd_router.sv
// coproc_cmd_router
//   Routes framed UART commands to operand registers and fixed-latency
//   coprocessor channels. Every accepted frame produces exactly one
//   response frame on the transmit side.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   frame_in/_valid   received frame (byte 0 = frame_in[7:0]) and strobe
//   frame_ready       high in IDLE only; frames offered otherwise are ignored
//   tx_frame/tx_send  response frame and one-cycle transmit trigger
//   tx_busy           UART transmitter busy; the response waits while high
//   regs_out          operand registers, reg n at [n*PB +: PB]
//   ch_start/ch_done  per-channel start pulse / completion pulse
//   ch_result         per-channel results, captured on ch_done
//   ch_busy           channel started and not yet done
//   err_count         saturating count of NAK responses
//
// Build option
//   CMD_XOR_CHECK_EN  when defined, the last frame byte (rx and tx) is the XOR
//                     of bytes 0..FRAME_BYTES-2 instead of a copy of byte 0.
module coproc_cmd_router #(
    parameter int FRAME_BYTES  = 18,
    parameter int PAYLOAD_BITS = (FRAME_BYTES - 2) * 8,
    parameter int NUM_REGS     = 4,
    parameter int NUM_CH       = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FRAME_BYTES*8-1:0]         frame_in,
    input  logic                             frame_valid,
    output logic                             frame_ready,
    output logic [FRAME_BYTES*8-1:0]         tx_frame,
    output logic                             tx_send,
    input  logic                             tx_busy,
    output logic [NUM_REGS*PAYLOAD_BITS-1:0] regs_out,
    output logic [NUM_CH-1:0]                ch_start,
    input  logic [NUM_CH-1:0]                ch_done,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0]   ch_result,
    output logic [NUM_CH-1:0]                ch_busy,
    output logic [15:0]                      err_count
);

    localparam int FW     = FRAME_BYTES * 8;
    localparam int PB     = PAYLOAD_BITS;
    localparam int PBYTES = PB / 8;

    localparam logic [7:0]  ST_ACK   = 8'h4B;
    localparam logic [7:0]  ST_DATA  = 8'h44;
    localparam logic [7:0]  ST_NAK   = 8'h4E;
    localparam logic [63:0] PING_PAT = 64'hEFCD_AB89_6745_2301;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q;
    logic [FW-1:0]     tx_frame_q;
    logic [PB-1:0]     regs_q [NUM_REGS];
    logic [PB-1:0]     res_q  [NUM_CH];
    logic [NUM_CH-1:0] rvalid_q;
    logic [NUM_CH-1:0] busy_q;
    logic [15:0]       err_q;

    // Decode results (pure functions of the latched frame and current state)
    logic [7:0]        op;
    logic [3:0]        idx;
    logic [7:0]        last_in;
    logic [7:0]        guard_exp;
    logic [7:0]        dec_status;
    logic [7:0]        dec_reason;
    logic [PB-1:0]     dec_payload;
    logic              dec_wr;
    logic              dec_start;
    logic [NUM_CH-1:0] start_vec;
    logic [PB-1:0]     reg_rd;
    logic [PB-1:0]     res_rd;
    logic              busy_sel;
    logic              rv_sel;
    logic              reg_ok;
    logic              ch_ok;
    logic              exec;
    logic [FW-1:0]     resp_frame;

`ifdef CMD_XOR_CHECK_EN
    function automatic logic [7:0] xor_bytes(input logic [FW-1:0] f);
        logic [7:0] x;
        x = '0;
        for (int unsigned b = 0; b < FRAME_BYTES - 1; b++) begin
            x ^= f[b*8 +: 8];
        end
        return x;
    endfunction
`endif

    assign op      = frame_q[7:0];
    assign idx     = op[3:0];
    assign last_in = frame_q[FW-8 +: 8];
    assign exec    = (state_q == S_EXEC);

`ifdef CMD_XOR_CHECK_EN
    assign guard_exp = xor_bytes(frame_q);
`else
    assign guard_exp = op;
`endif

    // Selected register/channel views for the current index
    always_comb begin
        reg_rd    = '0;
        res_rd    = '0;
        busy_sel  = 1'b0;
        rv_sel    = 1'b0;
        start_vec = '0;
        reg_ok    = ({1'b0, idx} < 5'(NUM_REGS));
        ch_ok     = ({1'b0, idx} < 5'(NUM_CH));
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (idx == 4'(n)) reg_rd = regs_q[n];
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (idx == 4'(c)) begin
                res_rd       = res_q[c];
                busy_sel     = busy_q[c];
                rv_sel       = rvalid_q[c];
                start_vec[c] = 1'b1;
            end
        end
    end

    // Opcode decode and response construction
    always_comb begin
        dec_status  = ST_ACK;
        dec_reason  = 8'h00;
        dec_payload = '0;
        dec_wr      = 1'b0;
        dec_start   = 1'b0;
        if (last_in != guard_exp) begin
            dec_reason = 8'h01;
        end else if (op == 8'h41) begin
            dec_status = ST_DATA;
            for (int unsigned b = 0; b < PBYTES; b++) begin
                dec_payload[b*8 +: 8] = PING_PAT[(b % 8)*8 +: 8];
            end
        end else begin
            case (op[7:4])
                4'h5: begin
                    if (reg_ok) dec_wr = 1'b1;
                    else        dec_reason = 8'h02;
                end
                4'h6: begin
                    if (reg_ok) begin
                        dec_status  = ST_DATA;
                        dec_payload = reg_rd;
                    end else begin
                        dec_reason = 8'h02;
                    end
                end
                4'h7: begin
                    if (!ch_ok)       dec_reason = 8'h02;
                    else if (busy_sel) dec_reason = 8'h03;
                    else              dec_start  = 1'b1;
                end
                4'h3: begin
                    if (!ch_ok) begin
                        dec_reason = 8'h02;
                    end else if (!rv_sel) begin
                        dec_reason = 8'h04;
                    end else begin
                        dec_status  = ST_DATA;
                        dec_payload = res_rd;
                    end
                end
                default: dec_reason = 8'h05;
            endcase
        end
        if (dec_reason != 8'h00) begin
            dec_status  = ST_NAK;
            dec_payload = '0;
            // byte loop keeps the op byte out of range-checked slices when PB == 8
            for (int unsigned b = 0; b < PBYTES; b++) begin
                if (b == 0) dec_payload[b*8 +: 8] = dec_reason;
                if (b == 1) dec_payload[b*8 +: 8] = op;
            end
        end
    end

    always_comb begin
        resp_frame         = '0;
        resp_frame[7:0]    = dec_status;
        resp_frame[8 +: PB] = dec_payload;
`ifdef CMD_XOR_CHECK_EN
        resp_frame[FW-8 +: 8] = xor_bytes(resp_frame);
`else
        resp_frame[FW-8 +: 8] = dec_status;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (!tx_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            tx_frame_q <= '0;
            rvalid_q   <= '0;
            busy_q     <= '0;
            err_q      <= '0;
            for (int unsigned n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) res_q[c] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && frame_valid) frame_q <= frame_in;
            if (exec) begin
                tx_frame_q <= resp_frame;
                if (dec_status == ST_NAK && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                if (dec_wr) begin
                    for (int unsigned n = 0; n < NUM_REGS; n++) begin
                        if (idx == 4'(n)) regs_q[n] <= frame_q[8 +: PB];
                    end
                end
            end
            // A start is only issued for an idle channel, so it never races a done
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_done[c] && busy_q[c]) begin
                    res_q[c]    <= ch_result[c*PB +: PB];
                    rvalid_q[c] <= 1'b1;
                    busy_q[c]   <= 1'b0;
                end else if (exec && dec_start && start_vec[c]) begin
                    busy_q[c]   <= 1'b1;
                    rvalid_q[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            regs_out[n*PB +: PB] = regs_q[n];
        end
    end

    assign frame_ready = (state_q == S_IDLE);
    assign tx_send     = (state_q == S_RESP) && !tx_busy;
    assign tx_frame    = tx_frame_q;
    assign ch_start    = (exec && dec_start) ? start_vec : '0;
    assign ch_busy     = busy_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_coproc_cmd_router.sv
module tb_coproc_cmd_router;

    localparam int FB = 18;
    localparam int FW = FB * 8;
    localparam int PB = (FB - 2) * 8;
    localparam int NR = 4;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     frame_in;
    logic              frame_valid;
    logic              frame_ready;
    logic [FW-1:0]     tx_frame;
    logic              tx_send;
    logic              tx_busy;
    logic [NR*PB-1:0]  regs_out;
    logic [NC-1:0]     ch_start;
    logic [NC-1:0]     ch_done;
    logic [NC*PB-1:0]  ch_result;
    logic [NC-1:0]     ch_busy;
    logic [15:0]       err_count;

    coproc_cmd_router #(
        .FRAME_BYTES(FB),
        .NUM_REGS   (NR),
        .NUM_CH     (NC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .tx_frame   (tx_frame),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .regs_out   (regs_out),
        .ch_start   (ch_start),
        .ch_done    (ch_done),
        .ch_result  (ch_result),
        .ch_busy    (ch_busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_sends  = 0;
    int starts0  = 0;
    int starts1  = 0;
    logic [FW-1:0] exp_q[$];

    localparam logic [127:0] PING  = {2{64'hEFCD_AB89_6745_2301}};
    localparam logic [127:0] WR1   = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    localparam logic [127:0] WR3   = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
    localparam logic [127:0] RES0  = 128'hF344_5566_7788_99AA_BBCC_DDEE_0011_22E6;
    localparam logic [127:0] RES1  = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] guard(input logic [7:0] b0, input logic [127:0] pl);
`ifdef CMD_XOR_CHECK_EN
        logic [7:0] x;
        x = b0;
        for (int i = 0; i < 16; i++) x ^= pl[i*8 +: 8];
        return x;
`else
        return b0;
`endif
    endfunction

    function automatic logic [FW-1:0] cmd(input logic [7:0] op, input logic [127:0] pl);
        return {guard(op, pl), pl, op};
    endfunction

    function automatic logic [FW-1:0] resp(input logic [7:0] st, input logic [127:0] pl);
        return {guard(st, pl), pl, st};
    endfunction

    function automatic logic [FW-1:0] nak(input logic [7:0] reason, input logic [7:0] op);
        return resp(8'h4E, {112'h0, op, reason});
    endfunction

    // Scoreboard consumer: every tx_send pops one expected response
    always @(negedge clk) begin
        if (tx_send) begin
            n_sends++;
            if (exp_q.size() == 0) check("spurious_send", 1, 0);
            else check("resp", tx_frame, exp_q.pop_front());
        end
        if (ch_start[0]) starts0++;
        if (ch_start[1]) starts1++;
    end

    task automatic wait_ready();
        int k = 0;
        while (!frame_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready", frame_ready, 1);
    endtask

    task automatic drive_frame(input logic [FW-1:0] f);
        @(posedge clk); #1;
        frame_in    = f;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic xact(input logic [FW-1:0] f, input logic [FW-1:0] e);
        wait_ready();
        exp_q.push_back(e);
        drive_frame(f);
        wait_drain();
    endtask

    initial begin
        logic [FW-1:0] cap;
        logic          stable;
        logic          rdy_low;
        int            s0;

        rst = 1'b0; frame_in = '0; frame_valid = 1'b0;
        tx_busy = 1'b0; ch_done = '0; ch_result = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", frame_ready, 1);
        check("rst_send", tx_send, 0);
        check("rst_txf", tx_frame, 0);
        check("rst_start", ch_start, 0);
        check("rst_busy", ch_busy, 0);
        check("rst_regs", regs_out, 0);
        check("rst_err", err_count, 0);

        // Ping with cycle-accurate latency
        wait_ready();
        exp_q.push_back(resp(8'h44, PING));
        drive_frame(cmd(8'h41, '0));
        @(negedge clk);
        check("lat1_send", tx_send, 0);
        check("lat1_ready", frame_ready, 0);
        @(negedge clk);
        check("lat2_send", tx_send, 1);
        @(negedge clk);
        check("lat3_send", tx_send, 0);
        check("lat3_ready", frame_ready, 1);
        wait_drain();

        xact(cmd(8'h31, '0), nak(8'h04, 8'h31));
        check("err_1", err_count, 1);

        xact(cmd(8'h51, WR1), resp(8'h4B, '0));
        xact(cmd(8'h61, '0), resp(8'h44, WR1));
        check("regs1", regs_out[255:128], WR1);
        xact(cmd(8'h53, WR3), resp(8'h4B, '0));
        xact(cmd(8'h63, '0), resp(8'h44, WR3));
        xact(cmd(8'h60, '0), resp(8'h44, '0));
        check("regs_all", regs_out, {WR3, 128'h0, WR1, 128'h0});

        // Channel 0 start / busy / done
        xact(cmd(8'h70, '0), resp(8'h4B, '0));
        check("start0_cnt", starts0, 1);
        check("busy0", ch_busy, 2'b01);
        xact(cmd(8'h70, '0), nak(8'h03, 8'h70));
        check("start0_cnt2", starts0, 1);
        check("err_2", err_count, 2);
        @(posedge clk); #1;
        ch_done = 2'b10; ch_result = {RES1, 128'h0};
        @(posedge clk); #1;
        ch_done = 2'b01; ch_result = {128'h0, RES0};
        @(posedge clk); #1;
        ch_done = '0; ch_result = '0;
        @(negedge clk);
        check("busy_cleared", ch_busy, 2'b00);
        xact(cmd(8'h31, '0), nak(8'h04, 8'h31));
        xact(cmd(8'h30, '0), resp(8'h44, RES0));

        // Error paths
        wait_ready();
        exp_q.push_back(nak(8'h01, 8'h41));
        drive_frame({8'h42, 128'h0, 8'h41});
        wait_drain();
        xact(cmd(8'h74, '0), nak(8'h02, 8'h74));
        xact(cmd(8'h54, WR1), nak(8'h02, 8'h54));
        xact(cmd(8'h64, '0), nak(8'h02, 8'h64));
        xact(cmd(8'h34, '0), nak(8'h02, 8'h34));
        xact(cmd(8'h99, '0), nak(8'h05, 8'h99));
        check("err_9", err_count, 9);
        check("start1_none", starts1, 0);

        // Read-result in the same cycle as ch_done sees pre-edge state
        xact(cmd(8'h71, '0), resp(8'h4B, '0));
        check("start1_cnt", starts1, 1);
        wait_ready();
        exp_q.push_back(nak(8'h04, 8'h31));
        drive_frame(cmd(8'h31, '0));
        ch_done = 2'b10; ch_result = {RES1, 128'h0};
        @(posedge clk); #1;
        ch_done = '0; ch_result = '0;
        wait_drain();
        check("busy1_done", ch_busy, 2'b00);
        xact(cmd(8'h31, '0), resp(8'h44, RES1));
        check("err_10", err_count, 10);

        // Transmitter back-pressure
        tx_busy = 1'b1;
        wait_ready();
        exp_q.push_back(resp(8'h44, PING));
        s0 = n_sends;
        drive_frame(cmd(8'h41, '0));
        @(posedge clk); #1;
        cap = tx_frame; stable = 1'b1; rdy_low = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx_frame !== cap) stable = 1'b0;
            if (frame_ready !== 1'b0) rdy_low = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_frame", cap, resp(8'h44, PING));
        check("hold_nosend", n_sends, s0);
        check("hold_ready", rdy_low, 1);
        tx_busy = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        check("hold_one_send", n_sends, s0 + 1);

        // Reset while a response is pending
        xact(cmd(8'h71, '0), resp(8'h4B, '0));
        check("busy1_set", ch_busy, 2'b10);
        tx_busy = 1'b1;
        wait_ready();
        s0 = n_sends;
        drive_frame(cmd(8'h41, '0));
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tx_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_ready", frame_ready, 1);
        check("mid_txf", tx_frame, 0);
        check("mid_busy", ch_busy, 0);
        check("mid_regs", regs_out, 0);
        check("mid_err", err_count, 0);
        check("mid_start", ch_start, 0);
        repeat (20) @(negedge clk);
        check("mid_nosend", n_sends, s0);
        xact(cmd(8'h30, '0), nak(8'h04, 8'h30));
        check("mid_err_1", err_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/coproc_cmd_router.md
Name: coproc_cmd_router

Overview:
Parametrised UART command router between the framed UART core and one or more fixed-latency coprocessors (AES encrypt/decrypt and similar).
- Accepts one received frame at a time and checks its integrity.
- Decodes the opcode, then writes operand registers, starts a channel, or reads back a register or result.
- Always returns exactly one response frame to the UART transmit side.
- Tracks per-channel busy/result-valid state, so a host never reads stale or in-flight results.

Parameters:
FRAME_BYTES, 18, bytes per frame (min 3); byte 0 = frame[7:0].
PAYLOAD_BITS, (FRAME_BYTES-2)*8, derived; payload = frame bytes 1..FRAME_BYTES-2.
NUM_REGS, 4, operand registers (1..16).
NUM_CH, 2, coprocessor channels (1..16).

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-low reset
frame_in  in  FRAME_BYTES*8  received frame from UART core
frame_valid  in  1  frame_in valid this cycle
frame_ready  out  1  router can accept a frame
tx_frame  out  FRAME_BYTES*8  response frame; held stable until the cycle after tx_send
tx_send  out  1  one-cycle transmit trigger
tx_busy  in  1  UART transmitter busy
regs_out  out  NUM_REGS*PAYLOAD_BITS  operand registers, reg n at [n*PB +: PB]
ch_start  out  NUM_CH  one-cycle start pulse per channel
ch_done  in  NUM_CH  one-cycle completion pulse per channel
ch_result  in  NUM_CH*PAYLOAD_BITS  channel results, sampled on ch_done
ch_busy  out  NUM_CH  channel started and not yet done
err_count  out  16  saturating count of NAK responses

Behaviour:
- Reset (rst=0 at posedge) clears the following:
  - FSM goes to IDLE; frame_ready=1.
  - tx_send=0, tx_frame=0, ch_start=0, ch_busy=0.
  - regs_out=0, all result registers and result-valid flags = 0, err_count=0.
  - Any pending response or start is dropped.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: frame_ready=1. On frame_valid, latch frame_in and go to EXEC. Frames arriving outside IDLE are ignored (frame_ready=0).
  - EXEC (1 cycle): integrity check, decode and side effects; build the response into tx_frame.
  - RESP: if tx_busy=0, pulse tx_send for 1 cycle and return to IDLE. Otherwise hold tx_frame and wait.
  - Minimum latency is frame_valid at cycle 0, tx_send at cycle 2, frame_ready high again at cycle 3.
- Integrity check: last byte must equal byte 0 (opcode). On mismatch, respond NAK with reason 0x01.
- Opcodes (op = byte 0, idx = op[3:0]):
  - 0x41 'A' ping: DATA response, payload = 0x0123..EF repeating, byte pattern 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF from byte 1.
  - 0x50|idx, write reg idx: reg <= payload; ACK.
  - 0x60|idx, read reg idx: DATA, payload = reg.
  - 0x70|idx, start channel idx:
    - If ch_busy[idx], respond NAK reason 0x03 and issue no pulse.
    - Otherwise ch_start[idx]=1 for the EXEC cycle, ch_busy[idx] is set, result-valid[idx] is cleared, and the response is ACK.
  - 0x30|idx, read result idx: DATA if result-valid[idx]; else NAK reason 0x04.
  - idx >= NUM_REGS or idx >= NUM_CH for the relevant opcode: NAK reason 0x02.
  - Any other op: NAK reason 0x05.
- Response frame layout:
  - byte 0 = status: 'K' (0x4B) ACK, 'D' (0x44) DATA, 'N' (0x4E) NAK.
  - Payload: DATA carries the value. NAK carries the reason in byte 1 and the offending op in byte 2, rest 0. ACK payload is 0.
  - Last byte = byte 0.
- Channel tracking:
  - ch_done[c] with ch_busy[c]=1 captures the result, sets result-valid[c] and clears ch_busy[c]. This happens in any FSM state.
  - ch_done[c] while ch_busy[c]=0 is ignored.
  - A read-result EXEC in the same cycle as ch_done for that channel uses pre-edge state, i.e. returns NAK 0x04.
- err_count increments on every NAK and saturates at 0xFFFF.

Optional Feature:
CMD_XOR_CHECK_EN
- Defined: the last byte of received and transmitted frames is the XOR of bytes 0..FRAME_BYTES-2 instead of an opcode copy. A mismatch gives NAK 0x01.
- Undefined: opcode-copy guard as described above.

Test Plan:
- Reset, then ping: frame byte0=0x41, last=0x41 -> tx_send at cycle 2; tx_frame byte0=0x44, bytes1..8 = 01 23 45 67 89 AB CD EF, last=0x44.
- Write reg 1 with payload 0x000102..0F, then read op 0x61 -> ACK 'K', then DATA with payload 0x000102..0F; regs_out[255:128] matches.
- Start op 0x70 -> ch_start[0] one pulse, ch_busy[0]=1. A second 0x70 gives NAK 'N', byte1=0x03, byte2=0x70. Drive ch_done[0] with result 0xF344..E6; 0x30 then returns DATA 0xF344..E6.
- Read 0x31 before any start -> NAK byte1=0x04; err_count increments to 1.
- Guard mismatch (byte0=0x41, last=0x42) -> NAK byte1=0x01. Op 0x74 with NUM_CH=2 -> NAK 0x02. Op 0x99 -> NAK 0x05.
- Hold tx_busy=1 for 50 cycles after a ping: tx_frame stable, no tx_send, frame_ready=0. Release tx_busy -> single tx_send. Assert rst=0 mid-wait -> tx_send never fires, all outputs at reset values.
